// File: rtl/contador_m_updown.sv
// contador_m_updown: modulo-M up/down counter with clamped load, terminal/half flags and wrap pulse
//   clock, reset (async, active-high), zera (sync clear), carrega (load D), conta (enable),
//   sentido (0 up / 1 down), D (load value) -> Q (count), fim, rco, meio, estouro
module contador_m_updown #(
   parameter int N = 4,
   parameter int M = 16
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         zera,
   input  logic         carrega,
   input  logic         conta,
   input  logic         sentido,
   input  logic [N-1:0] D,
   output logic [N-1:0] Q,
   output logic         fim,
   output logic         rco,
   output logic         meio,
   output logic         estouro
);
   localparam logic [N-1:0] MAX  = N'(M - 1);
   localparam logic [N-1:0] HALF = N'(M / 2);
   localparam logic [N-1:0] ONE  = N'(1);
   logic [N-1:0] r_q, w_load, w_step, w_next;
   logic         r_est, w_wrap;
   // fim marks the count about to wrap in the current direction, so it doubles as the wrap condition
   always_comb begin
      fim    = sentido ? (r_q == '0) : (r_q == MAX);
      rco    = fim & conta;
      meio   = r_q == HALF;
      w_load = (D > MAX) ? MAX : D;
      w_step = fim ? (sentido ? MAX : '0) : (sentido ? r_q - ONE : r_q + ONE);
      w_next = zera ? '0 : carrega ? w_load : conta ? w_step : r_q;
      w_wrap = ~zera & ~carrega & rco;
   end
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_q   <= '0;
         r_est <= 1'b0;
      end else begin
         r_q   <= w_next;
         r_est <= w_wrap;
      end
   end
   assign Q       = r_q;
   assign estouro = r_est;
endmodule
